// File: rtl/pong_renderer_pkg.sv
// Shared definitions for the Pong video stage: VGA 640x480@60 timing,
// the palette and a span test used by every object hit test.
package pong_renderer_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int CNT_W = 10;
    localparam int POS_W = 11;

    localparam logic [2:0] RGB_BALL = 3'b110;
    localparam logic [2:0] RGB_PAD  = 3'b111;
    localparam logic [2:0] RGB_NET  = 3'b001;
    localparam logic [2:0] RGB_BG   = 3'b000;

    // 11-bit operands keep lo+len from wrapping for any 10-bit position.
    function automatic logic in_span(input logic [POS_W-1:0] pos,
                                     input logic [POS_W-1:0] lo,
                                     input logic [POS_W-1:0] len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/pong_renderer_if.sv
// Game-state inputs and video outputs of the renderer, bundled as one port.
interface pong_renderer_if;

    logic [9:0] pad_left;
    logic [9:0] pad_right;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;
    logic       frame_start;

    modport master (
        output pad_left, pad_right, ball_x, ball_y,
        input  hsync, vsync, rgb, frame_start
    );

    modport slave (
        input  pad_left, pad_right, ball_x, ball_y,
        output hsync, vsync, rgb, frame_start
    );

endinterface

// File: rtl/pong_renderer_vga_timing.sv
// Pixel divider, h/v raster counters and the raw sync/visible/snapshot decode.
module pong_renderer_vga_timing
    import pong_renderer_pkg::*;
#(
    parameter int PIX_DIV = 2,
    parameter int H_VIS   = H_VISIBLE,
    parameter int H_FP    = H_FRONT,
    parameter int H_SY    = H_SYNC,
    parameter int H_BP    = H_BACK,
    parameter int V_VIS   = V_VISIBLE,
    parameter int V_FP    = V_FRONT,
    parameter int V_SY    = V_SYNC,
    parameter int V_BP    = V_BACK
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             visible,
    output logic             snap_strobe
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SY);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SY + H_BP - 1);

    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SY);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SY + V_BP - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    assign pix_en = (div_q == DIV_LAST);

    always_comb begin
        div_d   = pix_en ? '0 : div_q + 1'b1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign hsync_raw   = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vsync_raw   = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    assign visible     = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    // Start of vertical blanking: the frame is fully scanned out.
    assign snap_strobe = pix_en && (h_cnt_q == '0) && (v_cnt_q == V_VIS_C);

endmodule

// File: rtl/pong_renderer.sv
// Pong video stage: per-frame snapshot of the game state, object hit tests
// and a one-pixel registered output stage for rgb and the syncs.
module pong_renderer
    import pong_renderer_pkg::*;
#(
    parameter int PIX_DIV       = 2,
    parameter int SCREEN_WIDTH  = H_VISIBLE,
    parameter int SCREEN_HEIGHT = V_VISIBLE,
    parameter int PAD_WIDTH     = 8,
    parameter int PAD_HEIGHT    = 48,
    parameter int PAD_DISTANCE  = 16,
    parameter int BALL_SIZE     = 8,
    parameter int H_FRONT_PORCH = H_FRONT,
    parameter int H_SYNC_WIDTH  = H_SYNC,
    parameter int H_BACK_PORCH  = H_BACK,
    parameter int V_FRONT_PORCH = V_FRONT,
    parameter int V_SYNC_WIDTH  = V_SYNC,
    parameter int V_BACK_PORCH  = V_BACK
) (
    input  logic          clk,
    input  logic          rst,
    pong_renderer_if.slave vid
);

    localparam logic [POS_W-1:0] LPAD_X  = POS_W'(PAD_DISTANCE);
    localparam logic [POS_W-1:0] RPAD_X  = POS_W'(SCREEN_WIDTH - PAD_DISTANCE - PAD_WIDTH);
    localparam logic [POS_W-1:0] PAD_W   = POS_W'(PAD_WIDTH);
    localparam logic [POS_W-1:0] PAD_H   = POS_W'(PAD_HEIGHT);
    localparam logic [POS_W-1:0] BALL_SZ = POS_W'(BALL_SIZE);
    localparam logic [POS_W-1:0] NET_X   = POS_W'(SCREEN_WIDTH / 2 - 1);

    logic             pix_en, hsync_raw, vsync_raw, visible, snap_strobe;
    logic [CNT_W-1:0] h_cnt, v_cnt;

    pong_renderer_vga_timing #(
        .PIX_DIV (PIX_DIV),
        .H_VIS   (SCREEN_WIDTH),
        .H_FP    (H_FRONT_PORCH),
        .H_SY    (H_SYNC_WIDTH),
        .H_BP    (H_BACK_PORCH),
        .V_VIS   (SCREEN_HEIGHT),
        .V_FP    (V_FRONT_PORCH),
        .V_SY    (V_SYNC_WIDTH),
        .V_BP    (V_BACK_PORCH)
    ) u_vga_timing (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .visible     (visible),
        .snap_strobe (snap_strobe)
    );

    logic [9:0] pad_left_q, pad_left_d;
    logic [9:0] pad_right_q, pad_right_d;
    logic [9:0] ball_x_q, ball_x_d;
    logic [8:0] ball_y_q, ball_y_d;
    logic       snap_valid_q, snap_valid_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       frame_start_q, frame_start_d;
    logic [2:0] rgb_q, rgb_d;

    logic [POS_W-1:0] h_pos, v_pos;
    logic             ball_hit, lpad_hit, rpad_hit, net_hit;
    logic [2:0]       pixel;

    assign h_pos = {1'b0, h_cnt};
    assign v_pos = {1'b0, v_cnt};

    // Hit tests read only the snapshot, never the live game inputs.
    assign ball_hit = in_span(h_pos, {1'b0, ball_x_q}, BALL_SZ)
                   && in_span(v_pos, {2'b00, ball_y_q}, BALL_SZ);
    assign lpad_hit = in_span(h_pos, LPAD_X, PAD_W)
                   && in_span(v_pos, {1'b0, pad_left_q}, PAD_H);
    assign rpad_hit = in_span(h_pos, RPAD_X, PAD_W)
                   && in_span(v_pos, {1'b0, pad_right_q}, PAD_H);
    assign net_hit  = ((h_pos == NET_X) || (h_pos == NET_X + 1'b1)) && !v_cnt[4];

    always_comb begin
        pixel = RGB_BG;
        if (ball_hit)                  pixel = RGB_BALL;
        else if (lpad_hit || rpad_hit) pixel = RGB_PAD;
        else if (net_hit)              pixel = RGB_NET;
    end

    always_comb begin
        pad_left_d   = pad_left_q;
        pad_right_d  = pad_right_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        snap_valid_d = snap_valid_q;
        if (snap_strobe) begin
            pad_left_d   = vid.pad_left;
            pad_right_d  = vid.pad_right;
            ball_x_d     = vid.ball_x;
            ball_y_d     = vid.ball_y;
            snap_valid_d = 1'b1;
        end

        frame_start_d = snap_strobe;
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        if (pix_en) begin
            rgb_d   = (visible && snap_valid_q) ? pixel : RGB_BG;
            hsync_d = hsync_raw;
            vsync_d = vsync_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_left_q    <= '0;
            pad_right_q   <= '0;
            ball_x_q      <= '0;
            ball_y_q      <= '0;
            snap_valid_q  <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            rgb_q         <= RGB_BG;
        end else begin
            pad_left_q    <= pad_left_d;
            pad_right_q   <= pad_right_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            snap_valid_q  <= snap_valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.rgb         = rgb_q;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_pong_renderer.sv
// Bench for pong_renderer: a full-size instance checks line timing from reset,
// a shrunken-raster instance is checked pixel by pixel over several frames.
module tb_pong_renderer;

    // Shrunken raster: real VGA porches and syncs, small visible window.
    localparam int SW = 64, SH = 40, PW = 8, PH = 12, PD = 16, BS = 8;
    localparam int HT = SW + 16 + 96 + 48;
    localparam int VT = SH + 10 + 2 + 33;
    localparam int FRAME = HT * VT;
    localparam int FULL_CLKS = 3400;

    typedef struct {
        int         f;
        int         h;
        int         v;
        logic [2:0] rgb;
    } probe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pong_renderer_if vid_s ();
    pong_renderer_if vid_f ();

    pong_renderer #(
        .PIX_DIV       (1),
        .SCREEN_WIDTH  (SW),
        .SCREEN_HEIGHT (SH),
        .PAD_WIDTH     (PW),
        .PAD_HEIGHT    (PH),
        .PAD_DISTANCE  (PD),
        .BALL_SIZE     (BS)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .vid (vid_s.slave)
    );

    pong_renderer dut_full (
        .clk (clk),
        .rst (rst),
        .vid (vid_f.slave)
    );

    int     checks = 0;
    int     errors = 0;
    int     cyc;
    bit     m_valid;
    int     m_pl, m_pr, m_bx, m_by;
    probe_t probes [16];

    // Reference picture: what the screen should show at (h,v) for the snapshot.
    function automatic logic [2:0] exp_rgb(int h, int v);
        if (!m_valid || h >= SW || v >= SH)                             return 3'b000;
        if (h >= m_bx && h < m_bx + BS && v >= m_by && v < m_by + BS)   return 3'b110;
        if (h >= PD && h < PD + PW && v >= m_pl && v < m_pl + PH)       return 3'b111;
        if (h >= SW - PD - PW && h < SW - PD && v >= m_pr && v < m_pr + PH) return 3'b111;
        if ((h == SW / 2 - 1 || h == SW / 2) && (v % 32) < 16)          return 3'b001;
        return 3'b000;
    endfunction

    task automatic check(input string tag, input int k, input logic [5:0] got, input logic [5:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $display("FAIL %s pixel=%0d observed={hs,vs,rgb,fs}=%b expected=%b", tag, k, got, want);
            $error("check %s differs", tag);
        end
    endtask

    task automatic set_small(input int pl, input int pr, input int bx, input int by);
        vid_s.pad_left  = 10'(pl);
        vid_s.pad_right = 10'(pr);
        vid_s.ball_x    = 10'(bx);
        vid_s.ball_y    = 9'(by);
    endtask

    task automatic check_small(input int k);
        int h, v, f;
        logic [5:0] want;
        h = k % HT;
        v = (k / HT) % VT;
        f = k / FRAME;
        want = {!(h >= SW + 16 && h < SW + 112), !(v >= SH + 10 && v < SH + 12),
                exp_rgb(h, v), (h == 0 && v == SH)};
        check("small_px", k, {vid_s.hsync, vid_s.vsync, vid_s.rgb, vid_s.frame_start}, want);
        foreach (probes[i])
            if (probes[i].f == f && probes[i].h == h && probes[i].v == v)
                check("probe_rgb", k, {3'b000, vid_s.rgb}, {3'b000, probes[i].rgb});
        if (h == 0 && v == SH) begin
            m_valid = 1'b1;
            m_pl = int'(vid_s.pad_left);
            m_pr = int'(vid_s.pad_right);
            m_bx = int'(vid_s.ball_x);
            m_by = int'(vid_s.ball_y);
            $display("snapshot frame %0d: pad_left=%0d pad_right=%0d ball=(%0d,%0d)",
                     f, m_pl, m_pr, m_bx, m_by);
        end
        // Mid-frame changes must stay invisible; directed sets land just before the snapshot.
        if (h == 0 && v == 20)
            set_small($urandom_range(0, 60), $urandom_range(0, 60),
                      $urandom_range(0, 80), $urandom_range(0, 60));
        if (h == 0 && v == SH - 2) begin
            if (f == 0)      set_small(5, 34, 60, 36);
            else if (f == 1) set_small(20, 6, 42, 10);
        end
    endtask

    task automatic check_full(input int p);
        int h;
        logic [5:0] want;
        if (p < 0) begin
            want = 6'b110000;
        end else begin
            h = p % 800;
            want = {!(h >= 656 && h < 752), 1'b1, 3'b000, 1'b0};
        end
        check("full_line", p, {vid_f.hsync, vid_f.vsync, vid_f.rgb, vid_f.frame_start}, want);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_small(cyc - 1);
        if (cyc <= FULL_CLKS) check_full(cyc / 2 - 1);
    endtask

    initial begin
        probes = '{
            '{0, 10, 10, 3'b000},
            '{1, 63, 39, 3'b110}, '{1, 60, 36, 3'b110}, '{1,  0, 36, 3'b000},
            '{1,  3, 37, 3'b000}, '{1, 60,  0, 3'b000}, '{1, 16,  5, 3'b111},
            '{1, 23, 16, 3'b111}, '{1, 24,  5, 3'b000}, '{1, 16, 17, 3'b000},
            '{1, 40, 34, 3'b111},
            '{2, 42, 10, 3'b110}, '{2, 40, 10, 3'b111}, '{2, 31,  0, 3'b001},
            '{2, 31, 16, 3'b000}, '{2, 32, 15, 3'b001}
        };
        set_small(0, 0, 10, 10);
        vid_f.pad_left  = 10'd200;
        vid_f.pad_right = 10'd200;
        vid_f.ball_x    = 10'd100;
        vid_f.ball_y    = 9'd100;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_small", -1, {vid_s.hsync, vid_s.vsync, vid_s.rgb, vid_s.frame_start}, 6'b110000);
        check("reset_full", -1, {vid_f.hsync, vid_f.vsync, vid_f.rgb, vid_f.frame_start}, 6'b110000);

        rst = 1'b0;
        cyc = 0;
        m_valid = 1'b0;
        $display("run: 3 frames plus visible rows of a 4th");
        repeat (3 * FRAME + SH * HT) tick();

        $display("reset asserted mid-frame");
        rst = 1'b1;
        @(negedge clk);
        check("midreset_small", -1, {vid_s.hsync, vid_s.vsync, vid_s.rgb, vid_s.frame_start}, 6'b110000);
        check("midreset_full", -1, {vid_f.hsync, vid_f.vsync, vid_f.rgb, vid_f.frame_start}, 6'b110000);
        rst = 1'b0;
        cyc = 0;
        m_valid = 1'b0;
        repeat (1000) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_renderer.md
# pong_renderer

Downstream video stage of the Pong datapath. Consumes the game-state outputs of the game-logic block (`pad_left`, `pad_right`, `ball_x`, `ball_y`), generates 640x480@60 Hz VGA timing, and drives a registered 3-bit RGB pixel plus active-low syncs. Game state is snapshotted once per frame at the start of vertical blanking, so a frame is never torn by mid-frame game updates.

## Interface
- `PIX_DIV`, 2: system clocks per pixel; 2 gives 25 MHz pixels from a 50 MHz `clk`.
- `SCREEN_WIDTH`, 640: visible columns.
- `SCREEN_HEIGHT`, 480: visible rows.
- `PAD_WIDTH`, 8: pad width in pixels.
- `PAD_HEIGHT`, 48: pad height in pixels.
- `PAD_DISTANCE`, 16: gap from the screen edge to the pad's outer edge.
- `BALL_SIZE`, 8: ball square side in pixels.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `pad_left` in 10: top row of the left pad.
- `pad_right` in 10: top row of the right pad.
- `ball_x` in 10: left column of the ball.
- `ball_y` in 9: top row of the ball.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `rgb` out 3: {r,g,b}, one bit each; 0 outside the visible area.
- `frame_start` out 1: one-`clk` pulse when the snapshot is taken.

## Operation
- Pixel enable `pix_en` pulses one `clk` in every `PIX_DIV` clocks. All counters and outputs advance only on `pix_en`.
- `h_cnt` 0..799:
  - visible 0..639;
  - front porch 640..655;
  - sync 656..751;
  - back porch 752..799.
- `v_cnt` 0..524:
  - visible 0..479;
  - front porch 480..489;
  - sync 490..491;
  - back porch 492..524.
  - `v_cnt` increments when `h_cnt` wraps from 799 to 0. `v_cnt` 524 wraps to 0.
- Snapshot: on `pix_en` with `h_cnt`=0 and `v_cnt`=480, latch all four game inputs, set `snap_valid`, and pulse `frame_start`.
- Drawing uses only the snapshot registers. All comparisons are done 11 bits wide (zero-extended) so that `pos`+size cannot wrap.
  - Ball: `ball_x` ≤ h < `ball_x`+`BALL_SIZE` and `ball_y` ≤ v < `ball_y`+`BALL_SIZE` → 3'b110.
  - Left pad: `PAD_DISTANCE` ≤ h < `PAD_DISTANCE`+`PAD_WIDTH` and `pad_left` ≤ v < `pad_left`+`PAD_HEIGHT` → 3'b111.
  - Right pad: `SCREEN_WIDTH`-`PAD_DISTANCE`-`PAD_WIDTH` ≤ h < `SCREEN_WIDTH`-`PAD_DISTANCE`, with rows using `pad_right` → 3'b111.
  - Net: h ∈ {319,320} and v[4]=0 → 3'b001.
  - Priority: ball > pads > net > background 3'b000.
- Clipping: objects extending past row 479 or column 639 are simply not drawn beyond the visible area. Input values ≥ `SCREEN_HEIGHT` are legal and draw nothing off-screen.
- Blanking: `rgb`=0 whenever the pixel is not visible, and whenever `snap_valid`=0.

## Timing
- Reset values:
  - `h_cnt`=0, `v_cnt`=0, divider=0;
  - `hsync`=1, `vsync`=1, `rgb`=0, `frame_start`=0;
  - snapshot registers 0, `snap_valid`=0.
- The first `pix_en` occurs `PIX_DIV` clocks after `rst` deasserts.
- Pipeline is one pixel deep: `rgb`, `hsync` and `vsync` for counter position (h,v) are registered on the `pix_en` that evaluates (h,v). Syncs share this delay, so they stay aligned with `rgb`.
- Outputs hold their value between `pix_en` pulses.
- Input changes outside the snapshot instant have no visible effect until the next frame.
- `rst` asserted mid-frame: all state returns to reset values on the next edge. Video stays blank until the next `v_cnt`=480 snapshot.
- Frame period is 800×525×`PIX_DIV` clocks = 840000 with defaults.

## Structure
- A shared package holds:
  - VGA timing constants (visible, front porch, sync and back porch for H and V; totals);
  - RGB colour constants (ball, pad, net, background).
- Sub-module `vga_timing` contains the divider, the `h_cnt`/`v_cnt` counters, the raw sync decode, visible flag and snapshot strobe.
- `pong_renderer` holds the snapshot registers, hit tests and the output register stage.

## Test plan
- Reset then free-run one frame → `hsync` low for 96 pixels at `h_cnt` 656..751; `vsync` low for rows 490..491; line = 1600 clk; frame = 840000 clk; `frame_start` fires exactly once per frame.
- Before the first snapshot, drive `ball_x`=100, `ball_y`=100 → `rgb`=0 for the whole first frame.
- After a snapshot with `pad_left`=200 → `rgb`=3'b111 at (16,200) and (23,247); `rgb`=0 at (24,200) and (16,248).
- `ball_x`=636, `ball_y`=476 → 3'b110 at (639,479); nothing drawn at wrapped coordinates (0..3 or rows 0..3); no X on `rgb`.
- Change `ball_x` from 100 to 300 at `v_cnt`=200 → the current frame shows the ball at 100 on every row; the next frame shows it at 300.
- Ball overlapping the right pad at (620,100) with `pad_right`=90 → `rgb`=3'b110 at (620,100) (ball priority); net pixel (319,0) → 3'b001; (319,16) → 3'b000.
